// File: rtl/adat_frame_scheduler.sv
`timescale 1ns/1ps
// Frame sequencer for the ADAT transmit generator: paces frames at the sample
// rate, snapshots a per-channel shadow bank at launch and tracks under/overruns.
module adat_frame_scheduler #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int SAMPLE_RATE = 48000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [2:0]  s_channel,
  input  logic [23:0] s_data,
  input  logic [3:0]  user_in,
  output logic [23:0] gen_audio [0:7],
  output logic [3:0]  gen_user,
  output logic        gen_start,
  input  logic        gen_frame_done,
  output logic        busy,
  output logic [7:0]  stale_mask,
  output logic [15:0] underrun_count,
  output logic [15:0] overrun_count
);

  // Must be at least 4 so a tick can never coincide with the LAUNCH cycle.
  localparam int FRAME_CLOCKS = CLK_FREQ / SAMPLE_RATE;
  localparam int CNT_W        = $clog2(FRAME_CLOCKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CLOCKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE
  } state_t;

  state_t           state, state_nx;
  logic             run_q;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             wr_en;
  logic             transfer;
  logic             overrun_inc;
  logic [23:0]      shadow [0:7];
  logic [7:0]       fresh, fresh_nx;

  assign s_ready   = enable && !rst;
  assign wr_en     = s_valid && s_ready;
  assign tick      = enable && (cnt == CNT_LAST);
  assign gen_start = (state == LAUNCH);
  assign busy      = (state != IDLE);

  // The first enabled edge only arms the counter, so the first tick after
  // enable (or reset release) follows a full frame period from a zero count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the edge order of blocks does not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt   <= '0;
    end else begin
      run_q <= enable;
      if (!enable || !run_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: every always_comb output gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_nx    = state;
    transfer    = 1'b0;
    overrun_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick) begin
          state_nx = LAUNCH;
          transfer = 1'b1;
        end
      end
      LAUNCH: begin
        state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (gen_frame_done && tick) begin
          state_nx = LAUNCH;
          transfer = 1'b1;
        end else if (gen_frame_done) begin
          state_nx = IDLE;
        end else if (tick) begin
          overrun_inc = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // A write on the transfer edge misses this snapshot but stays fresh for the next.
  always_comb begin
    fresh_nx = transfer ? 8'h00 : fresh;
    if (wr_en) begin
      fresh_nx[s_channel] = 1'b1;
    end
  end

  // NOTE: the shadow bank is reset because unwritten channels are transmitted
  // as-is; without a reset the first frames would carry undefined samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
      end
      fresh <= '0;
    end else begin
      if (wr_en) begin
        shadow[s_channel] <= s_data;
      end
      fresh <= fresh_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        gen_audio[i] <= '0;
      end
      gen_user       <= '0;
      stale_mask     <= '0;
      underrun_count <= '0;
    end else if (transfer) begin
      for (int i = 0; i < 8; i++) begin
        gen_audio[i] <= shadow[i];
      end
      gen_user   <= user_in;
      stale_mask <= ~fresh;
      if (fresh != 8'hFF && underrun_count != 16'hFFFF) begin
        underrun_count <= underrun_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_count <= '0;
    end else if (overrun_inc && overrun_count != 16'hFFFF) begin
      overrun_count <= overrun_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_adat_frame_scheduler.sv
`timescale 1ns/1ps
// Self-checking bench for adat_frame_scheduler: abstract frame-timeline model,
// launch scoreboard, done-pulse stub and directed boundary scenarios.
module tb_adat_frame_scheduler;

  localparam int CLK_FREQ    = 2_400_000;
  localparam int SAMPLE_RATE = 48_000;
  localparam int FC          = CLK_FREQ / SAMPLE_RATE;  // 50 clocks per frame

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        s_valid;
  logic        s_ready;
  logic [2:0]  s_channel;
  logic [23:0] s_data;
  logic [3:0]  user_in;
  logic [23:0] gen_audio [0:7];
  logic [3:0]  gen_user;
  logic        gen_start;
  logic        gen_frame_done;
  logic        busy;
  logic [7:0]  stale_mask;
  logic [15:0] underrun_count;
  logic [15:0] overrun_count;

  adat_frame_scheduler #(
    .CLK_FREQ   (CLK_FREQ),
    .SAMPLE_RATE(SAMPLE_RATE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_channel     (s_channel),
    .s_data        (s_data),
    .user_in       (user_in),
    .gen_audio     (gen_audio),
    .gen_user      (gen_user),
    .gen_start     (gen_start),
    .gen_frame_done(gen_frame_done),
    .busy          (busy),
    .stale_mask    (stale_mask),
    .underrun_count(underrun_count),
    .overrun_count (overrun_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0]      cyc;
    logic [7:0][23:0] audio;
    logic [3:0]       user;
  } launch_t;

  launch_t          sb_q [$];
  launch_t          m_rec;
  int unsigned      m_cyc = 0;
  int unsigned      m_lcyc = 0;
  int               m_k = 0;
  bit               m_open = 1'b0;
  bit               m_tick, m_done;
  logic [7:0][23:0] m_shadow = '0;
  logic [7:0][23:0] m_audio = '0;
  logic [7:0]       m_fresh = '0;
  logic [7:0]       m_stale = '0;
  logic [3:0]       m_user = '0;
  int               m_under = 0;
  int               m_over = 0;

  // Frame timeline: m_k counts consecutive enabled edges; a tick lands on
  // every FC-th edge after the first one. A running frame accepts done only
  // from the second edge after its launch.
  initial forever begin
    @(posedge clk);
    m_cyc++;
    if (rst) begin
      m_k = 0; m_open = 0; m_shadow = '0; m_audio = '0; m_fresh = '0;
      m_stale = '0; m_user = '0; m_under = 0; m_over = 0;
    end else begin
      m_k    = enable ? m_k + 1 : 0;
      m_tick = enable && m_k > 1 && ((m_k - 1) % FC == 0);
      m_done = gen_frame_done && m_open && (m_cyc - m_lcyc >= 2);
      if (m_tick && (!m_open || m_done)) begin
        m_rec.cyc = m_cyc; m_rec.audio = m_shadow; m_rec.user = user_in;
        sb_q.push_back(m_rec);
        m_audio = m_shadow; m_user = user_in; m_stale = ~m_fresh;
        if (m_fresh != 8'hFF && m_under < 65535) m_under++;
        m_fresh = '0; m_open = 1; m_lcyc = m_cyc;
      end else if (m_tick) begin
        if (m_over < 65535) m_over++;
      end else if (m_done) begin
        m_open = 0;
      end
      if (s_valid && enable) begin
        m_shadow[s_channel] = s_data;
        m_fresh[s_channel]  = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int      n_starts = 0;
  launch_t mon_rec;

  initial forever begin
    @(posedge clk);
    #1;
    check("s_ready", s_ready, enable && !rst);
    check("busy", busy, m_open);
    check("stale_mask", stale_mask, m_stale);
    check("underrun_count", underrun_count, 64'(m_under));
    check("overrun_count", overrun_count, 64'(m_over));
    check("gen_user", gen_user, m_user);
    for (int i = 0; i < 8; i++) check("gen_audio", gen_audio[i], m_audio[i]);
    if (gen_start) begin
      n_starts++;
      check("start_has_expectation", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        mon_rec = sb_q.pop_front();
        check("start_cycle", m_cyc, mon_rec.cyc);
        check("start_user", gen_user, mon_rec.user);
        for (int i = 0; i < 8; i++) check("start_audio", gen_audio[i], mon_rec.audio[i]);
      end
    end else if (sb_q.size() != 0 && sb_q[0].cyc < m_cyc) begin
      check("start_missing_cycles", m_cyc - sb_q[0].cyc, 0);
      void'(sb_q.pop_front());
    end
  end

  // ---------------- generator stub ----------------
  int done_delay = 40;
  int done_cnt   = 0;
  bit rand_done  = 1'b0;

  initial begin
    gen_frame_done = 1'b0;
    forever begin
      @(negedge clk);
      gen_frame_done = 1'b0;
      if (rst) begin
        done_cnt = 0;
      end else begin
        if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) gen_frame_done = 1'b1;
        end
        if (rand_done && $urandom_range(0, 39) == 0) gen_frame_done = 1'b1;
        if (gen_start) done_cnt = done_delay;
      end
    end
  end

  // ---------------- stimulus ----------------
  int         wmode = 0;  // 0 none, 1 round-robin n+1, 2 random
  logic [2:0] rr_idx = '0;

  task automatic step();
    @(negedge clk);
    user_in = 4'($urandom);
    case (wmode)
      1: begin
        s_valid = 1'b1; s_channel = rr_idx; s_data = 24'(rr_idx) + 24'd1;
        rr_idx  = rr_idx + 3'd1;
      end
      2: begin
        s_valid = 1'($urandom_range(0, 1)); s_channel = 3'($urandom); s_data = 24'($urandom);
      end
      default: s_valid = 1'b0;
    endcase
  endtask

  task automatic wait_start();
    bit ok = 1'b0;
    for (int i = 0; i < 4 * FC + 10; i++) begin
      step();
      if (gen_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("start_within_budget", gen_start, 1);
  endtask

  int unsigned prev_l;
  int unsigned e0;
  int          n_wait;

  initial begin
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_channel = '0; s_data = '0; user_in = '0;

    // Reset values
    repeat (5) step();
    #1;
    check("rst_gen_start", gen_start, 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_stale", stale_mask, 0);
    check("rst_underrun", underrun_count, 0);
    check("rst_overrun", overrun_count, 0);
    check("rst_gen_user", gen_user, 0);
    for (int i = 0; i < 8; i++) check("rst_gen_audio", gen_audio[i], 0);
    step();
    rst = 1'b0;

    // Idle with enable low: random writes are refused, no frames
    wmode = 2;
    repeat (300) step();
    check("idle_no_start", n_starts, 0);
    for (int i = 0; i < 8; i++) check("idle_gen_audio", gen_audio[i], 0);

    // Nominal pacing
    wmode = 1; done_delay = 40;
    step();
    enable = 1'b1;
    e0 = m_cyc + 1;
    wait_start();
    check("first_start_latency", m_cyc - e0, FC);
    prev_l = m_cyc;
    repeat (4) begin
      wait_start();
      check("nominal_period", m_cyc - prev_l, FC);
      check("nominal_stale", stale_mask, 0);
      check("nominal_ch5", gen_audio[5], 24'h000006);
      prev_l = m_cyc;
    end

    // Underrun: last write lands two edges before the next launch
    repeat (FC - 3) step();
    wmode = 0;
    wait_start();
    check("underrun_clean_stale", stale_mask, 0);
    check("underrun_clean_count", underrun_count, 0);
    s_valid = 1'b1; s_channel = 3'd3; s_data = 24'hABCDEF;
    step();
    done_delay = FC - 1;
    wait_start();
    check("underrun_stale", stale_mask, 8'hF7);
    check("underrun_count", underrun_count, 1);
    check("underrun_ch3", gen_audio[3], 24'hABCDEF);
    check("underrun_ch0_held", gen_audio[0], 24'h000001);
    check("underrun_ch7_held", gen_audio[7], 24'h000008);
    prev_l = m_cyc;

    // done and tick together; write ch0 on the transfer edge
    repeat (FC - 1) step();
    s_valid = 1'b1; s_channel = 3'd0; s_data = 24'h123456;
    wait_start();
    check("simul_period", m_cyc - prev_l, FC);
    check("simul_overrun", overrun_count, 0);
    check("simul_ch0_not_yet", gen_audio[0], 24'h000001);
    prev_l = m_cyc;
    step();
    done_delay = 60;
    wait_start();
    check("simul_period2", m_cyc - prev_l, FC);
    check("simul_ch0_next", gen_audio[0], 24'h123456);
    check("simul_fresh0_kept", stale_mask[0], 0);
    check("simul_overrun2", overrun_count, 0);
    prev_l = m_cyc;

    // Overrun: every other tick dropped
    for (int k = 1; k <= 3; k++) begin
      wait_start();
      check("overrun_period", m_cyc - prev_l, 2 * FC);
      check("overrun_count_step", overrun_count, 64'(k));
      prev_l = m_cyc;
    end

    // Randomized traffic, spurious done pulses and an enable gap
    wmode = 2; rand_done = 1'b1;
    for (int i = 0; i < 800; i++) begin
      step();
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 4))
          0: done_delay = 5;
          1: done_delay = 20;
          2: done_delay = FC - 1;
          3: done_delay = 60;
          default: done_delay = 75;
        endcase
      end
      if (i == 300) enable = 1'b0;
      if (i == 340) enable = 1'b1;
    end

    // Mid-frame reset
    rand_done = 1'b0; wmode = 1; done_delay = 40;
    step();
    wait_start();
    wait_start();
    repeat (10) step();
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_gen_start", gen_start, 0);
    check("abort_underrun", underrun_count, 0);
    check("abort_overrun", overrun_count, 0);
    check("abort_stale", stale_mask, 0);
    check("abort_ch0", gen_audio[0], 0);
    step();
    rst = 1'b0;
    n_wait = 0;
    for (int i = 0; i < 3 * FC; i++) begin
      step();
      n_wait++;
      if (gen_start) break;
    end
    check("abort_restart_latency", n_wait, FC + 1);

    // Drain
    enable = 1'b0; wmode = 0;
    repeat (3 * FC) step();
    check("drain_queue_empty", sb_q.size(), 0);
    check("drain_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adat_frame_scheduler.md
# adat_frame_scheduler

Sequencer that feeds the ADAT transmit generator at the audio sample rate. Per-channel 24-bit samples arrive on a valid/ready write port into a shadow bank. A free-running frame-pace counter decides when a frame starts. On each frame tick the block launches one generator frame: it snapshots the bank, pulses start and waits for frame_done. It also counts underruns (channels not refreshed) and overruns (tick while a frame is still running). It sits between the audio source logic and the generator's audio_in/user_in/start/frame_done ports.

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- SAMPLE_RATE, 48000, frame rate in Hz
- FRAME_CLOCKS, CLK_FREQ/SAMPLE_RATE (2083 at defaults), derived localparam: clocks per frame period; must be ≥ 4
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  run control; low holds pace counter at 0, no new frames
- s_valid  in  1  sample write request
- s_ready  out  1  write accept; equals enable (low while rst or !enable)
- s_channel  in  3  target channel 0–7
- s_data  in  24  sample value
- user_in  in  4  user bits, sampled at frame launch
- gen_audio  out  24 × [0:7]  registered per-channel samples to generator
- gen_user  out  4  registered user bits to generator
- gen_start  out  1  one-cycle frame start pulse
- gen_frame_done  in  1  generator end-of-frame pulse
- busy  out  1  high when state ≠ IDLE
- stale_mask  out  8  bit n = channel n not written since previous launch, updated at launch
- underrun_count  out  16  saturating count of launches with any stale channel
- overrun_count  out  16  saturating count of dropped ticks

## Operation
- Pace counter: cnt 0..FRAME_CLOCKS-1, increments while enable, wraps to 0. tick = enable && cnt == FRAME_CLOCKS-1 (combinational). enable low → cnt forced to 0 next edge.
- Shadow bank shadow[0:7] (24 b) and fresh[7:0]. On s_valid && s_ready: shadow[s_channel] ← s_data, fresh[s_channel] ← 1. Unwritten channels retain their last value.
- FSM states IDLE, LAUNCH, WAIT_DONE:
  - IDLE: tick → LAUNCH, performing the transfer on that edge.
  - LAUNCH (exactly 1 cycle): gen_start = 1 → WAIT_DONE.
  - WAIT_DONE: gen_frame_done && tick → LAUNCH with transfer, no overrun. gen_frame_done alone → IDLE. tick alone → overrun_count +1 (sat.), tick dropped, stay.
- Transfer edge actions:
  - gen_audio ← shadow; gen_user ← user_in; stale_mask ← ~fresh.
  - If fresh ≠ 8'hFF, underrun_count +1 (saturates at 16'hFFFF).
  - fresh ← 0, except a write accepted on the same edge: its data is not in this snapshot, but it lands in shadow with fresh set for the next frame.
- gen_frame_done in IDLE or LAUNCH is ignored.
- enable falling during WAIT_DONE: the current frame completes normally, then the FSM returns to IDLE. No further ticks.
- Counters saturate and never wrap. They are cleared only by rst.

## Timing
- Reset values:
  - gen_audio all 0, gen_user 0, gen_start 0, busy 0, s_ready 0
  - stale_mask 0, underrun_count 0, overrun_count 0
  - state IDLE, cnt 0, shadow all 0, fresh 0
- rst asserted mid-frame: everything returns to reset values immediately (async). After release, the first tick needs a full FRAME_CLOCKS count.
- enable rises before edge E0: cnt = 0 in the cycle after E0. tick in the cycle FRAME_CLOCKS-1 after that. gen_start high the following cycle. Successive gen_start pulses are exactly FRAME_CLOCKS cycles apart when done arrives in time.
- gen_audio/gen_user are stable from the cycle gen_start rises until the next transfer edge (≥ FRAME_CLOCKS cycles).
- Write latency to shadow: 1 cycle. A write reaches gen_audio at the next transfer edge strictly after its acceptance edge.
- busy rises with gen_start and falls the cycle after the gen_frame_done edge.

## Test plan
- Reset/idle: rst high 5 cycles, enable 0 for 5000 cycles → all outputs at reset values, no gen_start.
- Nominal pacing: defaults, enable=1, stub done 2048 cycles after start, write ch0..7 = 24'h000001..24'h000008 each frame → gen_start period 2083. gen_audio[n] = n+1. stale_mask 0, underrun_count 0, overrun_count 0.
- Underrun: write only ch3 = 24'hABCDEF, then one frame → stale_mask 8'hF7, underrun_count 1, gen_audio[3] = 24'hABCDEF, other channels hold their previous values.
- Overrun: stub done 3000 cycles after start → every other tick dropped: overrun_count increments once per launch, launches 4166 cycles apart.
- Simultaneous events:
  - done and tick on the same edge → direct LAUNCH, overrun_count unchanged.
  - Write ch0 = 24'h123456 on the transfer edge → not in the current gen_audio[0]; present at the next launch; fresh[0] kept.
- Mid-frame abort: rst pulsed 1 cycle during WAIT_DONE → busy 0, counts 0, next gen_start exactly 2084 cycles after rst release with enable held high.
